// File: rtl/game_ctrl_multi.sv
// Game-flow controller for the stickman runner: level select, wait/play/win/lose
// sequencing, frame timer, coin bookkeeping and score for the renderers.
module game_ctrl_multi #(
    parameter int NUM_LEVELS = 2,
    parameter int NUM_COINS  = 3,
    parameter int FRAME_W    = 12,
    parameter int TIME_LIMIT = 1800,
    localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int SC_W  = $clog2(NUM_COINS + 1)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_clk,
    input  logic [7:0]            keycode,
    input  logic [NUM_COINS-1:0]  coin_hit,
    input  logic                  fell,
    output logic [4:0]            status,
    output logic [LVL_W-1:0]      level_sel,
    output logic [NUM_LEVELS-1:0] level_onehot,
    output logic [FRAME_W-1:0]    frame_counter,
    output logic [NUM_COINS-1:0]  coin_taken,
    output logic [SC_W-1:0]       score,
    output logic                  restart
);

    localparam logic [7:0] KEY_LVL0  = 8'h1E;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_R     = 8'h15;
    localparam logic [FRAME_W-1:0] FRAME_LIMIT = FRAME_W'(TIME_LIMIT);

    // State encoding is the status vector itself, so status is one-hot by construction.
    typedef enum logic [4:0] {
        S_SELECT = 5'b10000,
        S_WAIT   = 5'b01000,
        S_PLAY   = 5'b00100,
        S_WIN    = 5'b00010,
        S_LOSE   = 5'b00001
    } state_t;

    state_t                 state, state_n;
    logic [LVL_W-1:0]       level_n;
    logic [FRAME_W-1:0]     frame_n;
    logic [NUM_COINS-1:0]   coin_n, coin_upd;
    logic                   restart_n;
    logic [7:0]             keycode_q;
    logic [7:0]             key_off;
    logic                   key_new;
    logic                   vs_meta, vs_sync, vs_prev;
    logic                   frame_tick;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_meta   <= 1'b0;
            vs_sync   <= 1'b0;
            vs_prev   <= 1'b0;
            keycode_q <= 8'h00;
        end else begin
            vs_meta   <= frame_clk;
            vs_sync   <= vs_meta;
            vs_prev   <= vs_sync;
            keycode_q <= keycode;
        end
    end

    assign frame_tick = vs_sync & ~vs_prev;
    assign key_new    = (keycode != 8'h00) && (keycode != keycode_q);
    assign key_off    = keycode - KEY_LVL0;
    assign coin_upd   = coin_taken | coin_hit;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= S_SELECT;
            level_sel     <= '0;
            frame_counter <= '0;
            coin_taken    <= '0;
            restart       <= 1'b0;
        end else begin
            state         <= state_n;
            level_sel     <= level_n;
            frame_counter <= frame_n;
            coin_taken    <= coin_n;
            restart       <= restart_n;
        end
    end

    always_comb begin
        state_n   = state;
        level_n   = level_sel;
        frame_n   = frame_counter;
        coin_n    = coin_taken;
        restart_n = 1'b0;

        // Escape overrides everything, including coin and fall events this cycle.
        if (key_new && keycode == KEY_ESC) begin
            state_n = S_SELECT;
        end else begin
            case (state)
                S_SELECT: begin
                    if (key_new && keycode >= KEY_LVL0 && key_off < 8'(NUM_LEVELS)) begin
                        level_n   = key_off[LVL_W-1:0];
                        state_n   = S_WAIT;
                        frame_n   = '0;
                        coin_n    = '0;
                        restart_n = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (key_new && keycode == KEY_SPACE) begin
                        state_n = S_PLAY;
                        frame_n = '0;
                        coin_n  = '0;
                    end
                end
                S_PLAY: begin
                    coin_n = coin_upd;
                    if (frame_tick && frame_counter != FRAME_LIMIT)
                        frame_n = frame_counter + FRAME_W'(1);
                    // A win in the same cycle as a fall or timeout takes precedence.
                    if (&coin_upd)
                        state_n = S_WIN;
                    else if (fell || frame_counter == FRAME_LIMIT)
                        state_n = S_LOSE;
                end
                S_WIN, S_LOSE: begin
                    if (key_new && keycode == KEY_ENTER) begin
                        state_n = S_SELECT;
                    end else if (key_new && keycode == KEY_R) begin
                        state_n   = S_WAIT;
                        frame_n   = '0;
                        coin_n    = '0;
                        restart_n = 1'b1;
                    end
                end
                default: state_n = S_SELECT;
            endcase
        end
    end

    assign status       = state;
    assign level_onehot = NUM_LEVELS'(1) << level_sel;

    always_comb begin
        score = '0;
        for (int i = 0; i < NUM_COINS; i++)
            score = score + SC_W'(coin_taken[i]);
    end

endmodule
